// File: rtl/cell_pos_ctrl.sv
// Cell position RAM controller: streams a cell's particles to the force pipeline and arbitrates the RAM port with motion-update writes.
// Optional count clamping and the sticky cnt_err flag are enabled by defining CELL_POS_CTRL_COUNT_CHECK_EN.
module cell_pos_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_start,
    output logic                  rd_busy,
    output logic                  rd_done,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_pid,
    output logic                  out_last,
    output logic                  cnt_err,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ack,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    typedef enum logic [2:0] {
        IDLE, WRITE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE
    } state_t;

    state_t                  state, state_nxt;
    logic                    wait_q, wait_nxt;
    logic                    pending, pending_nxt;
    logic [ADDR_WIDTH-1:0]   cnt, cnt_nxt;
    logic [ADDR_WIDTH-1:0]   n_raw, n_eff;
    logic                    wr_grant;
    logic                    cnt_capture;

    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [DATA_WIDTH-1:0]   data_nxt;
    logic                    rden_nxt, wren_nxt, busy_nxt, done_nxt;
    logic                    vld0_nxt, last0_nxt;

    logic                    vld_p0, vld_p1, vld_p2;
    logic [ADDR_WIDTH-1:0]   pid_p0, pid_p1, pid_p2;
    logic                    last_p0, last_p1, last_p2;

    assign n_raw       = ram_q[ADDR_WIDTH-1:0];
    assign cnt_capture = (state == WAIT_CNT) && wait_q;

`ifdef CELL_POS_CTRL_COUNT_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    logic err_q;

    function automatic logic [ADDR_WIDTH-1:0] clamp_cnt(input logic [ADDR_WIDTH-1:0] n);
        return (n > MAX_CNT) ? MAX_CNT : n;
    endfunction

    assign n_eff   = clamp_cnt(n_raw);
    assign cnt_err = err_q;

    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (cnt_capture && (n_raw > MAX_CNT))
            err_q <= 1'b1;
    end
`else
    assign n_eff   = n_raw;
    assign cnt_err = 1'b0;
`endif

    // A read that is pending always wins over a new write so the stream cannot starve.
    assign wr_grant = (state == IDLE) && wr_req && !pending && !rst;
    assign wr_ack   = wr_grant;
    assign out_data = ram_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wait_q  <= 1'b0;
            pending <= 1'b0;
            cnt     <= '0;
        end else begin
            state   <= state_nxt;
            wait_q  <= wait_nxt;
            pending <= pending_nxt;
            cnt     <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (wr_grant) state_nxt = WRITE;
                      else if (rd_start || pending) state_nxt = RD_CNT;
            WRITE:    state_nxt = (pending || rd_start) ? RD_CNT : IDLE;
            RD_CNT:   state_nxt = WAIT_CNT;
            WAIT_CNT: if (wait_q) state_nxt = (n_eff == '0) ? DONE : STREAM;
            STREAM:   if (ram_address == cnt) state_nxt = DRAIN;
            DRAIN:    if (wait_q) state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        wait_nxt    = ((state == WAIT_CNT) || (state == DRAIN)) && !wait_q;
        pending_nxt = (pending || (wr_grant && rd_start)) && (state_nxt != RD_CNT);
        cnt_nxt     = cnt_capture ? n_eff : cnt;

        addr_nxt = '0;
        data_nxt = '0;
        rden_nxt = 1'b0;
        wren_nxt = 1'b0;
        vld0_nxt = 1'b0;
        case (state_nxt)
            WRITE: begin
                addr_nxt = wr_addr;
                data_nxt = wr_data;
                wren_nxt = 1'b1;
            end
            RD_CNT: rden_nxt = 1'b1;
            STREAM: begin
                rden_nxt = 1'b1;
                vld0_nxt = 1'b1;
                addr_nxt = (state == STREAM) ? ram_address + ADDR_WIDTH'(1) : ADDR_WIDTH'(1);
            end
            default: ;
        endcase
        last0_nxt = vld0_nxt && (addr_nxt == cnt_nxt);
        busy_nxt  = (state_nxt == RD_CNT) || (state_nxt == WAIT_CNT) ||
                    (state_nxt == STREAM) || (state_nxt == DRAIN);
        done_nxt  = (state_nxt == DONE);
    end

    // Stage p0 travels with the RAM address; p1/p2 follow the 2-cycle RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_address <= '0;
            ram_data    <= '0;
            ram_rden    <= 1'b0;
            ram_wren    <= 1'b0;
            rd_busy     <= 1'b0;
            rd_done     <= 1'b0;
            vld_p0 <= 1'b0; pid_p0 <= '0; last_p0 <= 1'b0;
            vld_p1 <= 1'b0; pid_p1 <= '0; last_p1 <= 1'b0;
            vld_p2 <= 1'b0; pid_p2 <= '0; last_p2 <= 1'b0;
        end else begin
            ram_address <= addr_nxt;
            ram_data    <= data_nxt;
            ram_rden    <= rden_nxt;
            ram_wren    <= wren_nxt;
            rd_busy     <= busy_nxt;
            rd_done     <= done_nxt;
            vld_p0 <= vld0_nxt; pid_p0 <= addr_nxt; last_p0 <= last0_nxt;
            vld_p1 <= vld_p0;   pid_p1 <= pid_p0;   last_p1 <= last_p0;
            vld_p2 <= vld_p1;   pid_p2 <= pid_p1;   last_p2 <= last_p1;
        end
    end

    assign out_valid = vld_p2;
    assign out_pid   = vld_p2 ? pid_p2 : '0;
    assign out_last  = last_p2;

endmodule
